// File: rtl/msg_serializer_if.sv
// msg_serializer_if: message input handshake and byte output stream of msg_serializer.
// slave is the serializer's view; master is the view of the logic driving and draining it.
interface msg_serializer_if;
    logic [0:295] msgIn;
    logic         msgIn_lost;
    logic         msgIn_val;
    logic         msgIn_ready;
    logic [7:0]   dataOut;
    logic         dataOut_val;
    logic         dataOut_ready;
    logic         dataOut_last;

    modport slave (
        input  msgIn, msgIn_lost, msgIn_val, dataOut_ready,
        output msgIn_ready, dataOut, dataOut_val, dataOut_last
    );

    modport master (
        output msgIn, msgIn_lost, msgIn_val, dataOut_ready,
        input  msgIn_ready, dataOut, dataOut_val, dataOut_last
    );
endinterface

// File: rtl/msg_serializer.sv
// msg_serializer: buffers 37-byte parsed messages in a small FIFO and emits each
// one as a 38-byte frame (status header {6'b0, bad, lost} followed by bytes 0..36).
// Optional saturating statistics counters are compiled in when
// MSG_SERIALIZER_STATS_EN is defined; otherwise the counter outputs are tied to 0.
module msg_serializer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    msg_serializer_if.slave  bus,
    output logic [CNT_W-1:0] msgCount,
    output logic [CNT_W-1:0] lostCount,
    output logic [CNT_W-1:0] badCount
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 298;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    state_t        state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [0:EW-1] fifo_mem [DEPTH];

    logic          full, empty, push, in_bad;
    logic [0:EW-1] head;
    logic [0:295]  head_msg;
    logic          head_lost, head_bad;
    logic [8:0]    bit_base;
    logic [7:0]    data_out;
    logic          data_val, data_last;

    // Occupancy comes from registered pointers only, so ready never depends on a same-cycle pop.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign bus.msgIn_ready = !full && !reset;
    assign push   = bus.msgIn_val && bus.msgIn_ready;
    assign in_bad = &bus.msgIn;

    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign head_msg  = head[0:295];
    assign head_lost = head[296];
    assign head_bad  = head[297];
    assign bit_base  = {idx_q, 3'b000};

    assign bus.dataOut      = data_out;
    assign bus.dataOut_val  = data_val;
    assign bus.dataOut_last = data_last;

    // FIFO pointer update and serializer next-state / output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_ptr_d  = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        data_out  = 8'h00;
        data_val  = 1'b0;
        data_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = HEADER;
            end
            HEADER: begin
                data_val = 1'b1;
                data_out = {6'b0, head_bad, head_lost};
                if (bus.dataOut_ready) begin
                    state_d = PAYLOAD;
                    idx_d   = 6'd0;
                end
            end
            PAYLOAD: begin
                data_val  = 1'b1;
                data_out  = head_msg[bit_base +: 8];
                data_last = (idx_q == 6'd36);
                if (bus.dataOut_ready) begin
                    if (idx_q == 6'd36) begin
                        // Pop the finished message; go straight to the next header if one remains.
                        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                        idx_d    = 6'd0;
                        state_d  = (wr_ptr_d != rd_ptr_d) ? HEADER : IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, byte index and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= 6'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage: message, lost flag and bad-length flag captured on accept.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {bus.msgIn, bus.msgIn_lost, in_bad};
    end

`ifdef MSG_SERIALIZER_STATS_EN
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Statistics counters advance on input accept and stick at all-ones.
    always_comb begin
        msg_cnt_d  = sat_inc(msg_cnt_q, push);
        lost_cnt_d = sat_inc(lost_cnt_q, push && bus.msgIn_lost);
        bad_cnt_d  = sat_inc(bad_cnt_q, push && in_bad);
    end

    // Statistics counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            msg_cnt_q  <= '0;
            lost_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            msg_cnt_q  <= msg_cnt_d;
            lost_cnt_q <= lost_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign msgCount  = msg_cnt_q;
    assign lostCount = lost_cnt_q;
    assign badCount  = bad_cnt_q;
`else
    assign msgCount  = '0;
    assign lostCount = '0;
    assign badCount  = '0;
`endif
endmodule

// File: tb/tb_msg_serializer.sv
// tb_msg_serializer: directed bench for msg_serializer (DEPTH=2). A second instance
// with CNT_W=2 exercises counter saturation. Counter expectations follow
// MSG_SERIALIZER_STATS_EN (zero when the statistics block is compiled out).
module tb_msg_serializer;
`ifdef MSG_SERIALIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset2 = 1'b1;
    logic [CNT_W-1:0] msg_cnt, lost_cnt, bad_cnt;
    logic [1:0] msg_cnt2, lost_cnt2, bad_cnt2;
    int tests_run = 0;
    int tests_failed = 0;
    int unsigned cyc_cnt = 0;
    bit sat_done = 1'b0;

    msg_serializer_if bus();
    msg_serializer_if bus2();

    msg_serializer #(.DEPTH(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .msgCount(msg_cnt), .lostCount(lost_cnt), .badCount(bad_cnt)
    );

    msg_serializer #(.DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset2), .bus(bus2.slave),
        .msgCount(msg_cnt2), .lostCount(lost_cnt2), .badCount(bad_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:295] pack(input logic [7:0] p [37]);
        logic [0:295] m;
        for (int i = 0; i < 37; i++) m[8*i +: 8] = p[i];
        return m;
    endfunction

    task automatic chk_cnts(input string tag, input int m, input int l, input int b);
        chk({tag, "_msgCount"},  32'(msg_cnt),  STATS ? m : 0);
        chk({tag, "_lostCount"}, 32'(lost_cnt), STATS ? l : 0);
        chk({tag, "_badCount"},  32'(bad_cnt),  STATS ? b : 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Present a message and hold it until accepted; seen = cycle in which ready was observed.
    task automatic push_msg(input logic [0:295] m, input logic lost, output int unsigned seen);
        int w = 0;
        bus.msgIn      = m;
        bus.msgIn_lost = lost;
        bus.msgIn_val  = 1'b1;
        while (!bus.msgIn_ready && w < 500) begin
            tick();
            w++;
        end
        chk("push_accept_in_time", 32'(w < 500), 1);
        seen = cyc_cnt;
        tick();
        bus.msgIn_val = 1'b0;
    endtask

    // Consume one 38-byte frame, checking every valid byte (including held ones) and last.
    task automatic recv_frame(input string tag, input logic [7:0] hdr, input logic [7:0] pay [37],
                              input bit stall, input bit immediate);
        int n = 0;
        int cyc = 0;
        logic rdy;
        logic [7:0] exp;
        if (immediate) chk({tag, "_no_bubble"}, 32'(bus.dataOut_val), 1);
        while (n < 38 && cyc < 4000) begin
            rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.dataOut_ready = rdy;
            if (bus.dataOut_val) begin
                if (n == 0) exp = hdr;
                else        exp = pay[n-1];
                chk($sformatf("%s_byte%0d", tag, n), 32'(bus.dataOut), 32'(exp));
                chk($sformatf("%s_last%0d", tag, n), 32'(bus.dataOut_last), 32'(n == 37));
                if (rdy) n++;
            end else if (n > 0) begin
                chk($sformatf("%s_val_drop%0d", tag, n), 32'(bus.dataOut_val), 1);
                break;
            end
            tick();
            cyc++;
        end
        chk({tag, "_len"}, n, 38);
    endtask

    // Main directed sequence.
    initial begin
        logic [7:0] p1 [37];
        logic [7:0] pff [37];
        logic [7:0] pa [37];
        logic [7:0] pb [37];
        logic [7:0] pc [37];
        int unsigned t_seen, t_done, t_dummy;
        int n, w;

        for (int i = 0; i < 37; i++) begin
            p1[i]  = 8'(i + 1);
            pff[i] = 8'hFF;
            pa[i]  = 8'(8'h40 + i);
            pb[i]  = 8'(8'h80 + i);
            pc[i]  = 8'(8'hC0 + i);
        end
        bus.msgIn = '0;
        bus.msgIn_lost = 1'b0;
        bus.msgIn_val = 1'b0;
        bus.dataOut_ready = 1'b0;

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ready_low", 32'(bus.msgIn_ready), 0);
        reset = 1'b0;
        tick();
        chk("rst_ready_high", 32'(bus.msgIn_ready), 1);
        chk("rst_val", 32'(bus.dataOut_val), 0);
        chk("rst_data", 32'(bus.dataOut), 0);
        chk("rst_last", 32'(bus.dataOut_last), 0);
        chk_cnts("rst", 0, 0, 0);

        // Single message 0x01..0x25, latency and framing.
        bus.dataOut_ready = 1'b1;
        push_msg(pack(p1), 1'b0, t_dummy);
        chk("t1_idle_after_accept", 32'(bus.dataOut_val), 0);
        tick();
        chk("t1_header_2nd_cycle", 32'(bus.dataOut_val), 1);
        recv_frame("t1", 8'h00, p1, 1'b0, 1'b0);
        chk("t1_idle_after_frame", 32'(bus.dataOut_val), 0);
        chk("t1_data_zero_idle", 32'(bus.dataOut), 0);
        chk_cnts("t1", 1, 0, 0);

        // All-0xFF message with lost flag.
        do_reset();
        push_msg(pack(pff), 1'b1, t_dummy);
        tick();
        recv_frame("t2", 8'h03, pff, 1'b0, 1'b0);
        chk_cnts("t2", 1, 1, 1);

        // FIFO full back-pressure and back-to-back frames.
        do_reset();
        bus.dataOut_ready = 1'b0;
        push_msg(pack(pa), 1'b0, t_dummy);
        chk("t3_ready_one_entry", 32'(bus.msgIn_ready), 1);
        push_msg(pack(pb), 1'b0, t_dummy);
        chk("t3_ready_full", 32'(bus.msgIn_ready), 0);
        fork
            push_msg(pack(pc), 1'b0, t_seen);
            begin
                recv_frame("t3a", 8'h00, pa, 1'b0, 1'b1);
                t_done = cyc_cnt;
                recv_frame("t3b", 8'h00, pb, 1'b0, 1'b1);
            end
        join
        chk("t3_c_accept_after_last", t_seen, t_done);
        recv_frame("t3c", 8'h00, pc, 1'b0, 1'b1);
        chk("t3_idle", 32'(bus.dataOut_val), 0);
        chk_cnts("t3", 3, 0, 0);

        // Random output stalls across three frames.
        do_reset();
        bus.dataOut_ready = 1'b0;
        push_msg(pack(pa), 1'b1, t_dummy);
        push_msg(pack(pb), 1'b0, t_dummy);
        fork
            push_msg(pack(pc), 1'b1, t_dummy);
            begin
                recv_frame("t4a", 8'h01, pa, 1'b1, 1'b1);
                recv_frame("t4b", 8'h00, pb, 1'b1, 1'b1);
            end
        join
        recv_frame("t4c", 8'h01, pc, 1'b1, 1'b1);
        bus.dataOut_ready = 1'b0;
        chk_cnts("t4", 3, 2, 0);

        // Reset in the middle of a frame at payload index 10.
        do_reset();
        push_msg(pack(p1), 1'b0, t_dummy);
        push_msg(pack(pa), 1'b0, t_dummy);
        bus.dataOut_ready = 1'b1;
        n = 0;
        w = 0;
        while (n < 11 && w < 100) begin
            if (bus.dataOut_val) n++;
            tick();
            w++;
        end
        chk("t5_reach_idx10", n, 11);
        chk("t5_idx10_byte", 32'(bus.dataOut), 32'h0B);
        chk_cnts("t5_pre", 2, 0, 0);
        reset = 1'b1;
        tick();
        chk("t5_val_after_rst", 32'(bus.dataOut_val), 0);
        chk("t5_last_after_rst", 32'(bus.dataOut_last), 0);
        chk("t5_data_after_rst", 32'(bus.dataOut), 0);
        chk("t5_ready_in_rst", 32'(bus.msgIn_ready), 0);
        chk_cnts("t5_rst", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("t5_ready_after_rst", 32'(bus.msgIn_ready), 1);
        tick();
        tick();
        chk("t5_fifo_flushed", 32'(bus.dataOut_val), 0);
        push_msg(pack(pb), 1'b1, t_dummy);
        tick();
        recv_frame("t5", 8'h01, pb, 1'b0, 1'b0);
        chk_cnts("t5_post", 1, 1, 0);

        // Wait for the saturation sequence on the second instance.
        w = 0;
        while (!sat_done && w < 5000) begin
            tick();
            w++;
        end
        chk("sat_done", 32'(sat_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Counter saturation on the CNT_W=2 instance: five lost messages.
    initial begin
        logic [7:0] ps [37];
        int w;
        for (int i = 0; i < 37; i++) ps[i] = 8'(8'h10 + i);
        bus2.msgIn = '0;
        bus2.msgIn_lost = 1'b0;
        bus2.msgIn_val = 1'b0;
        bus2.dataOut_ready = 1'b1;
        reset2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus2.msgIn = pack(ps);
            bus2.msgIn_lost = 1'b1;
            bus2.msgIn_val = 1'b1;
            w = 0;
            while (!bus2.msgIn_ready && w < 500) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk("sat_push_in_time", 32'(w < 500), 1);
            @(posedge clk);
            #1;
            bus2.msgIn_val = 1'b0;
        end
        chk("sat_lostCount", 32'(lost_cnt2), STATS ? 3 : 0);
        chk("sat_msgCount", 32'(msg_cnt2), STATS ? 3 : 0);
        chk("sat_badCount", 32'(bad_cnt2), 0);
        sat_done = 1'b1;
    end
endmodule

// File: doc/msg_serializer.md
# msg_serializer

Downstream stage of the sequence parser. Accepts one 296-bit parsed message (37 bytes) plus its packet-lost flag per handshake, buffers it in a small FIFO, and re-emits it as a byte stream with valid/ready/last framing. Each output frame is one status header byte followed by the 37 message bytes. Optional saturating counters track message, lost-packet and bad-length totals.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- CNT_W, 16, width of each statistics counter

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- msgIn  in  [0:295]  parsed message; bits [0:7] are byte 0
- msgIn_lost  in  1  packet-lost flag qualified by msgIn_val
- msgIn_val  in  1  message valid
- msgIn_ready  out  1  space available; `!full`
- dataOut  out  8  output byte
- dataOut_val  out  1  byte valid
- dataOut_ready  in  1  downstream accepts byte
- dataOut_last  out  1  final byte of frame
- msgCount  out  CNT_W  messages accepted
- lostCount  out  CNT_W  accepted messages with msgIn_lost=1
- badCount  out  CNT_W  accepted bad-length messages

## Operation
- Input accept: `msgIn_val && msgIn_ready`. Push {msgIn, msgIn_lost, bad} into FIFO; `bad` = all 37 bytes equal 8'hFF, computed at push.
- FIFO: DEPTH entries of 298 bits; read/write pointers with an extra wrap bit; full = pointers equal except wrap bit; empty = pointers equal.
- No input-to-output bypass; a message always passes through the FIFO.
- Serializer FSM:
  - IDLE: when FIFO non-empty → HEADER.
  - HEADER: dataOut = {6'b0, bad, lost}; on accept → PAYLOAD, byte index = 0.
  - PAYLOAD: dataOut = head byte[index]; on accept increment index; at index 36 assert dataOut_last; on accept pop FIFO, then → HEADER if FIFO still non-empty after pop, else IDLE.
- dataOut_val = 1 in HEADER and PAYLOAD only; dataOut/dataOut_last are 0 when dataOut_val = 0.
- Byte index is a 6-bit counter; never exceeds 36.
- Simultaneous push and pop: both take effect; occupancy unchanged; a push is permitted when full only if it is not full at the start of the cycle (i.e. msgIn_ready is registered-state based, not pop-dependent).
- Counters increment on input accept; saturate at all-ones; no wrap.
- dataOut_val, once asserted, holds with stable dataOut until accepted.

## Timing
- Reset: FIFO empty, state IDLE, index 0, msgIn_ready=1 (after reset deassert), dataOut_val=0, dataOut=0, dataOut_last=0, all counters 0. msgIn_ready=0 while reset=1.
- Latency: message accepted at edge N → FSM leaves IDLE at N+1 → header byte valid in cycle after edge N+1.
- Frame length: exactly 38 accepted bytes; full throughput one byte/cycle with dataOut_ready=1.
- Back-to-back frames: next header valid in the cycle immediately after last byte accepted (no bubble) when FIFO non-empty.
- Reset mid-frame: frame aborted, no dataOut_last, FIFO contents discarded.

## Configuration
- MSG_SERIALIZER_STATS_EN defined: msgCount/lostCount/badCount registers and increment logic compiled in as above.
- Not defined: counters removed; the three outputs tied to 0; bad/lost header bits still generated.

## Test plan
- Single message bytes 0x01..0x25, lost=0, dataOut_ready=1 → header 0x00 then 0x01..0x25, dataOut_last only on 0x25, first byte valid 2 cycles after accept.
- Message all 0xFF, lost=1 → header 0x03, 37 bytes 0xFF; badCount=1, lostCount=1, msgCount=1.
- DEPTH=2: push 3 messages with dataOut_ready=0 → msgIn_ready drops after 2nd accept; 3rd accepted only after first frame's last byte accepted.
- Random dataOut_ready stalls → byte held stable while val&!ready; 38 bytes per frame, correct order, 3 frames back-to-back without bubble when ready=1.
- Reset asserted at payload index 10 → dataOut_val=0 next cycle, counters 0, msgIn_ready=1 after deassert, next message starts with header.
- Counter saturation with CNT_W=2: 5 lost messages → lostCount=3.
